// File: rtl/axi_pkg.sv
// Shared AXI4 encodings and FSM state type for the burst master.
package axi_pkg;

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE,
      S_AW,
      S_W,
      S_B,
      S_AR,
      S_R,
      S_ERR
   } state_e;

endpackage

// File: rtl/axi_master_burst.sv
// Single-outstanding AXI4 INCR burst master with command/stream front end.
// Define AXI_MASTER_4K_CHECK_EN to reject commands that cross a 4 KB page.
module axi_master_burst
   import axi_pkg::*;
#(
   parameter int AXI_DATA_WIDTH = 256,
   parameter int AXI_ADDR_WIDTH = 64,
   parameter int AXI_ID_WIDTH   = 4,
   parameter int AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8,
   parameter int AXI_USER_WIDTH = 1,
   parameter int TX_ID          = 0,
   parameter int ADDR_LSB       = $clog2(AXI_DATA_WIDTH / 8)
) (
   input  logic                      clk,
   input  logic                      rst_n,

   input  logic                      cmd_valid,
   output logic                      cmd_ready,
   input  logic                      cmd_write,
   input  logic [AXI_ADDR_WIDTH-1:0] cmd_addr,
   input  logic [7:0]                cmd_len,

   input  logic                      wr_valid,
   output logic                      wr_ready,
   input  logic [AXI_DATA_WIDTH-1:0] wr_data,
   input  logic [AXI_STRB_WIDTH-1:0] wr_strb,

   output logic                      rd_valid,
   input  logic                      rd_ready,
   output logic [AXI_DATA_WIDTH-1:0] rd_data,
   output logic                      rd_last,

   output logic                      done_valid,
   output logic [1:0]                done_resp,
   output logic                      busy,

   output logic [AXI_ADDR_WIDTH-1:0] aw_addr,
   output logic [2:0]                aw_prot,
   output logic [3:0]                aw_region,
   output logic [7:0]                aw_len,
   output logic [2:0]                aw_size,
   output logic [1:0]                aw_burst,
   output logic                      aw_lock,
   output logic [3:0]                aw_cache,
   output logic [3:0]                aw_qos,
   output logic [AXI_ID_WIDTH-1:0]   aw_id,
   output logic [AXI_USER_WIDTH-1:0] aw_user,
   output logic                      aw_valid,
   input  logic                      aw_ready,

   output logic [AXI_ADDR_WIDTH-1:0] ar_addr,
   output logic [2:0]                ar_prot,
   output logic [3:0]                ar_region,
   output logic [7:0]                ar_len,
   output logic [2:0]                ar_size,
   output logic [1:0]                ar_burst,
   output logic                      ar_lock,
   output logic [3:0]                ar_cache,
   output logic [3:0]                ar_qos,
   output logic [AXI_ID_WIDTH-1:0]   ar_id,
   output logic [AXI_USER_WIDTH-1:0] ar_user,
   output logic                      ar_valid,
   input  logic                      ar_ready,

   output logic                      w_valid,
   output logic [AXI_DATA_WIDTH-1:0] w_data,
   output logic [AXI_STRB_WIDTH-1:0] w_strb,
   output logic [AXI_USER_WIDTH-1:0] w_user,
   output logic                      w_last,
   input  logic                      w_ready,

   input  logic [AXI_DATA_WIDTH-1:0] r_data,
   input  logic [1:0]                r_resp,
   input  logic                      r_last,
   input  logic [AXI_ID_WIDTH-1:0]   r_id,
   input  logic [AXI_USER_WIDTH-1:0] r_user,
   input  logic                      r_valid,
   output logic                      r_ready,

   input  logic [1:0]                b_resp,
   input  logic [AXI_ID_WIDTH-1:0]   b_id,
   input  logic [AXI_USER_WIDTH-1:0] b_user,
   input  logic                      b_valid,
   output logic                      b_ready
);

   localparam logic [AXI_ADDR_WIDTH-1:0] ALIGN_MASK =
      {{(AXI_ADDR_WIDTH-ADDR_LSB){1'b1}}, {ADDR_LSB{1'b0}}};

   state_e                    state_q, state_d;
   logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [7:0]                len_q, len_d;
   logic [7:0]                cnt_q, cnt_d;
   logic [1:0]                resp_q, resp_d;
   logic                      done_d;
   logic [1:0]                done_resp_d;
   logic                      w_hs, r_hs;
   logic                      unused_inputs;

   assign unused_inputs = ^{b_id, b_user, r_id, r_user};

`ifdef AXI_MASTER_4K_CHECK_EN
   logic [AXI_ADDR_WIDTH-1:0] cmd_base, cmd_span, cmd_end;
   logic                      cross_4k;

   always_comb begin
      cmd_base = cmd_addr & ALIGN_MASK;
      cmd_span = AXI_ADDR_WIDTH'({1'b0, cmd_len} + 9'd1) << ADDR_LSB;
      cmd_end  = cmd_base + cmd_span - {{(AXI_ADDR_WIDTH-1){1'b0}}, 1'b1};
      cross_4k = cmd_end[AXI_ADDR_WIDTH-1:12] != cmd_base[AXI_ADDR_WIDTH-1:12];
   end
`endif

   assign cmd_ready = state_q == S_IDLE;
   assign busy      = state_q != S_IDLE;

   assign aw_valid  = state_q == S_AW;
   assign aw_addr   = addr_q;
   assign aw_len    = len_q;
   assign aw_size   = 3'(ADDR_LSB);
   assign aw_burst  = BURST_INCR;
   assign aw_id     = AXI_ID_WIDTH'(TX_ID);
   assign aw_prot   = '0;
   assign aw_region = '0;
   assign aw_lock   = 1'b0;
   assign aw_cache  = '0;
   assign aw_qos    = '0;
   assign aw_user   = '0;

   assign ar_valid  = state_q == S_AR;
   assign ar_addr   = addr_q;
   assign ar_len    = len_q;
   assign ar_size   = 3'(ADDR_LSB);
   assign ar_burst  = BURST_INCR;
   assign ar_id     = AXI_ID_WIDTH'(TX_ID);
   assign ar_prot   = '0;
   assign ar_region = '0;
   assign ar_lock   = 1'b0;
   assign ar_cache  = '0;
   assign ar_qos    = '0;
   assign ar_user   = '0;

   assign w_valid   = (state_q == S_W) && wr_valid;
   assign wr_ready  = (state_q == S_W) && w_ready;
   assign w_data    = wr_data;
   assign w_strb    = wr_strb;
   assign w_user    = '0;
   assign w_last    = (state_q == S_W) && (cnt_q == len_q);
   assign w_hs      = w_valid && w_ready;

   assign rd_valid  = (state_q == S_R) && r_valid;
   assign r_ready   = (state_q == S_R) && rd_ready;
   assign rd_data   = r_data;
   assign rd_last   = r_last;
   assign r_hs      = r_valid && r_ready;

   assign b_ready   = state_q == S_B;

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      len_d       = len_q;
      cnt_d       = cnt_q;
      resp_d      = resp_q;
      done_d      = 1'b0;
      done_resp_d = done_resp;
      unique case (state_q)
         S_IDLE: begin
            if (cmd_valid) begin
               addr_d  = cmd_addr & ALIGN_MASK;
               len_d   = cmd_len;
               cnt_d   = '0;
               resp_d  = RESP_OKAY;
               state_d = cmd_write ? S_AW : S_AR;
`ifdef AXI_MASTER_4K_CHECK_EN
               if (cross_4k) state_d = S_ERR;
`endif
            end
         end
         S_AW: if (aw_ready) state_d = S_W;
         S_W: begin
            if (w_hs) begin
               cnt_d = cnt_q + 8'd1;
               if (cnt_q == len_q) state_d = S_B;
            end
         end
         S_B: begin
            if (b_valid) begin
               done_d      = 1'b1;
               done_resp_d = b_resp;
               state_d     = S_IDLE;
            end
         end
         S_AR: if (ar_ready) state_d = S_R;
         S_R: begin
            if (r_hs) begin
               cnt_d = cnt_q + 8'd1;
               // first non-OKAY response wins for the whole burst
               if (resp_q == RESP_OKAY) resp_d = r_resp;
               if (r_last) begin
                  done_d      = 1'b1;
                  done_resp_d = (cnt_q != len_q) ? RESP_SLVERR : resp_d;
                  state_d     = S_IDLE;
               end
            end
         end
         S_ERR: begin
            done_d      = 1'b1;
            done_resp_d = RESP_SLVERR;
            state_d     = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         addr_q     <= '0;
         len_q      <= '0;
         cnt_q      <= '0;
         resp_q     <= RESP_OKAY;
         done_valid <= 1'b0;
         done_resp  <= RESP_OKAY;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         len_q      <= len_d;
         cnt_q      <= cnt_d;
         resp_q     <= resp_d;
         done_valid <= done_d;
         done_resp  <= done_resp_d;
      end
   end

endmodule

// File: tb/tb_axi_master_burst.sv
// Directed self-checking bench for axi_master_burst.
// Honours AXI_MASTER_4K_CHECK_EN when the design is built with it.
module tb_axi_master_burst;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          cmd_valid, cmd_ready, cmd_write;
   logic [63:0]   cmd_addr;
   logic [7:0]    cmd_len;
   logic          wr_valid, wr_ready;
   logic [255:0]  wr_data;
   logic [31:0]   wr_strb;
   logic          rd_valid, rd_ready, rd_last;
   logic [255:0]  rd_data;
   logic          done_valid, busy;
   logic [1:0]    done_resp;
   logic [63:0]   aw_addr, ar_addr;
   logic [2:0]    aw_prot, ar_prot, aw_size, ar_size;
   logic [3:0]    aw_region, ar_region, aw_cache, ar_cache, aw_qos, ar_qos;
   logic [7:0]    aw_len, ar_len;
   logic [1:0]    aw_burst, ar_burst;
   logic          aw_lock, ar_lock, aw_valid, ar_valid, aw_ready, ar_ready;
   logic [3:0]    aw_id, ar_id, r_id, b_id;
   logic [0:0]    aw_user, ar_user, w_user, r_user, b_user;
   logic          w_valid, w_last, w_ready;
   logic [255:0]  w_data, r_data;
   logic [31:0]   w_strb;
   logic [1:0]    r_resp, b_resp;
   logic          r_last, r_valid, r_ready, b_valid, b_ready;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   axi_master_burst dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
      .wr_valid(wr_valid), .wr_ready(wr_ready),
      .wr_data(wr_data), .wr_strb(wr_strb),
      .rd_valid(rd_valid), .rd_ready(rd_ready),
      .rd_data(rd_data), .rd_last(rd_last),
      .done_valid(done_valid), .done_resp(done_resp), .busy(busy),
      .aw_addr(aw_addr), .aw_prot(aw_prot), .aw_region(aw_region),
      .aw_len(aw_len), .aw_size(aw_size), .aw_burst(aw_burst),
      .aw_lock(aw_lock), .aw_cache(aw_cache), .aw_qos(aw_qos),
      .aw_id(aw_id), .aw_user(aw_user),
      .aw_valid(aw_valid), .aw_ready(aw_ready),
      .ar_addr(ar_addr), .ar_prot(ar_prot), .ar_region(ar_region),
      .ar_len(ar_len), .ar_size(ar_size), .ar_burst(ar_burst),
      .ar_lock(ar_lock), .ar_cache(ar_cache), .ar_qos(ar_qos),
      .ar_id(ar_id), .ar_user(ar_user),
      .ar_valid(ar_valid), .ar_ready(ar_ready),
      .w_valid(w_valid), .w_data(w_data), .w_strb(w_strb),
      .w_user(w_user), .w_last(w_last), .w_ready(w_ready),
      .r_data(r_data), .r_resp(r_resp), .r_last(r_last),
      .r_id(r_id), .r_user(r_user), .r_valid(r_valid), .r_ready(r_ready),
      .b_resp(b_resp), .b_id(b_id), .b_user(b_user),
      .b_valid(b_valid), .b_ready(b_ready)
   );

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      n_cmp++;
      if ({aw_valid, ar_valid, w_valid, r_ready, b_ready, rd_valid, wr_ready}
          !== 7'b0) begin
         n_bad++;
         $display("FAIL reset_valids got %b want 0000000",
            {aw_valid, ar_valid, w_valid, r_ready, b_ready, rd_valid, wr_ready});
      end
      n_cmp++;
      if (done_valid !== 1'b0 || done_resp !== 2'b00 || busy !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_done got dv=%b dr=%b busy=%b want 0 00 0",
            done_valid, done_resp, busy);
      end
      rst_n = 1'b1;
      @(negedge clk);
      #1;
      n_cmp++;
      if (cmd_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL reset_cmd_ready got %b want 1", cmd_ready);
      end
   endtask

   task automatic run_write(input logic [63:0] addr, input int len,
                            input int aw_delay, input bit gap,
                            input string tag);
      int beats;
      int cyc;
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_write = 1'b1;
      cmd_addr  = addr;
      cmd_len   = 8'(len);
      #1;
      n_cmp++;
      if (cmd_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL %s_cmd_ready got %b want 1", tag, cmd_ready);
      end
      @(negedge clk);
      cmd_valid = 1'b0;
      wr_valid  = 1'b1;
      wr_data   = 256'hA;
      w_ready   = 1'b1;
      for (int i = 0; i < aw_delay; i++) begin
         aw_ready = 1'b0;
         #1;
         n_cmp++;
         if (aw_valid !== 1'b1 || aw_addr !== addr || aw_len !== 8'(len)) begin
            n_bad++;
            $display("FAIL %s_aw_hold got v=%b a=%h l=%0d want 1 %h %0d",
               tag, aw_valid, aw_addr, aw_len, addr, len);
         end
         n_cmp++;
         if (w_valid !== 1'b0 || wr_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL %s_w_before_aw got w_valid=%b wr_ready=%b want 0 0",
               tag, w_valid, wr_ready);
         end
         @(negedge clk);
      end
      aw_ready = 1'b1;
      #1;
      n_cmp++;
      if (aw_valid !== 1'b1 || aw_addr !== addr || aw_len !== 8'(len) ||
          aw_size !== 3'd5 || aw_burst !== 2'b01 || aw_id !== 4'd0) begin
         n_bad++;
         $display("FAIL %s_aw got v=%b a=%h l=%0d s=%0d b=%0d id=%0d want 1 %h %0d 5 1 0",
            tag, aw_valid, aw_addr, aw_len, aw_size, aw_burst, aw_id, addr, len);
      end
      @(negedge clk);
      aw_ready = 1'b0;
      beats = 0;
      cyc = 0;
      while (beats <= len && cyc < 64) begin
         wr_valid = gap ? (cyc % 2 == 0) : 1'b1;
         wr_data  = 256'hA + 256'(beats);
         wr_strb  = '1;
         #1;
         if (wr_valid) begin
            n_cmp++;
            if (w_valid !== 1'b1 || w_data !== 256'hA + 256'(beats) ||
                w_last !== (beats == len)) begin
               n_bad++;
               $display("FAIL %s_w_beat%0d got v=%b d=%h last=%b want 1 %h %b",
                  tag, beats, w_valid, w_data, w_last,
                  256'hA + 256'(beats), beats == len);
            end
            beats++;
         end else begin
            n_cmp++;
            if (w_valid !== 1'b0) begin
               n_bad++;
               $display("FAIL %s_w_gap got w_valid=%b want 0", tag, w_valid);
            end
         end
         cyc++;
         @(negedge clk);
      end
      wr_valid = 1'b0;
      n_cmp++;
      if (beats != len + 1) begin
         n_bad++;
         $display("FAIL %s_beats got %0d want %0d", tag, beats, len + 1);
      end
      b_valid = 1'b1;
      b_resp  = 2'b00;
      #1;
      n_cmp++;
      if (b_ready !== 1'b1 || done_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL %s_b got b_ready=%b done=%b want 1 0",
            tag, b_ready, done_valid);
      end
      @(negedge clk);
      b_valid = 1'b0;
      #1;
      n_cmp++;
      if (done_valid !== 1'b1 || done_resp !== 2'b00 || cmd_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL %s_done got dv=%b dr=%b cr=%b want 1 00 1",
            tag, done_valid, done_resp, cmd_ready);
      end
      @(negedge clk);
      #1;
      n_cmp++;
      if (done_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL %s_done_pulse got %b want 0", tag, done_valid);
      end
   endtask

   task automatic run_read(input logic [63:0] addr, input int len,
                           input int err_beat, input int last_beat,
                           input bit toggle, input logic [1:0] exp_resp,
                           input string tag);
      int beats;
      int cyc;
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_write = 1'b0;
      cmd_addr  = addr;
      cmd_len   = 8'(len);
      #1;
      n_cmp++;
      if (cmd_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL %s_cmd_ready got %b want 1", tag, cmd_ready);
      end
      @(negedge clk);
      cmd_valid = 1'b0;
      ar_ready  = 1'b1;
      #1;
      n_cmp++;
      if (ar_valid !== 1'b1 || ar_addr !== addr || ar_len !== 8'(len) ||
          ar_size !== 3'd5 || ar_burst !== 2'b01 || aw_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL %s_ar got v=%b a=%h l=%0d s=%0d b=%0d aw=%b want 1 %h %0d 5 1 0",
            tag, ar_valid, ar_addr, ar_len, ar_size, ar_burst, aw_valid, addr, len);
      end
      @(negedge clk);
      ar_ready = 1'b0;
      rd_ready = 1'b1;
      beats = 0;
      cyc = 0;
      while (beats <= last_beat && cyc < 200) begin
         r_valid = toggle ? 1'($urandom_range(0, 1)) : 1'b1;
         r_data  = 256'h100 + 256'(beats);
         r_last  = beats == last_beat;
         r_resp  = (beats == err_beat) ? 2'b10 : 2'b00;
         #1;
         if (r_valid) begin
            n_cmp++;
            if (rd_valid !== 1'b1 || r_ready !== 1'b1 ||
                rd_data !== 256'h100 + 256'(beats) ||
                rd_last !== (beats == last_beat)) begin
               n_bad++;
               $display("FAIL %s_r_beat%0d got v=%b rr=%b d=%h last=%b",
                  tag, beats, rd_valid, r_ready, rd_data, rd_last);
            end
            beats++;
         end else begin
            n_cmp++;
            if (rd_valid !== 1'b0) begin
               n_bad++;
               $display("FAIL %s_r_idle got rd_valid=%b want 0", tag, rd_valid);
            end
         end
         cyc++;
         @(negedge clk);
      end
      r_valid = 1'b0;
      r_last  = 1'b0;
      r_resp  = 2'b00;
      n_cmp++;
      if (beats != last_beat + 1) begin
         n_bad++;
         $display("FAIL %s_beats got %0d want %0d", tag, beats, last_beat + 1);
      end
      #1;
      n_cmp++;
      if (done_valid !== 1'b1 || done_resp !== exp_resp || cmd_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL %s_done got dv=%b dr=%b cr=%b want 1 %b 1",
            tag, done_valid, done_resp, cmd_ready, exp_resp);
      end
      @(negedge clk);
      #1;
      n_cmp++;
      if (done_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL %s_done_pulse got %b want 0", tag, done_valid);
      end
   endtask

   task automatic test_write();
      run_write(64'h100, 3, 0, 1'b0, "write");
   endtask

   task automatic test_read();
      run_read(64'h40, 7, 99, 7, 1'b1, 2'b00, "read");
   endtask

   task automatic test_read_err();
      run_read(64'h80, 3, 1, 3, 1'b0, 2'b10, "read_slverr");
      run_read(64'hC0, 3, 99, 1, 1'b0, 2'b10, "read_short");
   endtask

   task automatic test_backpressure();
      run_write(64'h200, 2, 5, 1'b1, "bp");
   endtask

   task automatic test_4k();
`ifdef AXI_MASTER_4K_CHECK_EN
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_write = 1'b1;
      cmd_addr  = 64'hFE0;
      cmd_len   = 8'd1;
      @(negedge clk);
      cmd_valid = 1'b0;
      aw_ready  = 1'b1;
      #1;
      n_cmp++;
      if (aw_valid !== 1'b0 || ar_valid !== 1'b0 || done_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL 4k_err got aw=%b ar=%b dv=%b want 0 0 0",
            aw_valid, ar_valid, done_valid);
      end
      @(negedge clk);
      #1;
      n_cmp++;
      if (done_valid !== 1'b1 || done_resp !== 2'b10 || aw_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL 4k_done got dv=%b dr=%b aw=%b want 1 10 0",
            done_valid, done_resp, aw_valid);
      end
      aw_ready = 1'b0;
      @(negedge clk);
`else
      run_write(64'hFE0, 1, 0, 1'b0, "no4k");
`endif
   endtask

   task automatic test_reset_mid();
      bit saw_done;
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_write = 1'b1;
      cmd_addr  = 64'h300;
      cmd_len   = 8'd3;
      @(negedge clk);
      cmd_valid = 1'b0;
      aw_ready  = 1'b1;
      @(negedge clk);
      aw_ready = 1'b0;
      wr_valid = 1'b1;
      w_ready  = 1'b1;
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      #1;
      n_cmp++;
      if ({aw_valid, ar_valid, w_valid, wr_ready, b_ready, r_ready, busy}
          !== 7'b0) begin
         n_bad++;
         $display("FAIL rstmid_valids got %b want 0000000",
            {aw_valid, ar_valid, w_valid, wr_ready, b_ready, r_ready, busy});
      end
      rst_n = 1'b1;
      wr_valid = 1'b0;
      saw_done = done_valid;
      repeat (3) begin
         @(negedge clk);
         #1;
         saw_done = saw_done | done_valid;
      end
      n_cmp++;
      if (saw_done !== 1'b0) begin
         n_bad++;
         $display("FAIL rstmid_no_done got %b want 0", saw_done);
      end
      run_write(64'h400, 1, 0, 1'b0, "after_rst");
   endtask

   initial begin
      rst_n     = 1'b0;
      cmd_valid = 1'b0;
      cmd_write = 1'b0;
      cmd_addr  = '0;
      cmd_len   = '0;
      wr_valid  = 1'b0;
      wr_data   = '0;
      wr_strb   = '1;
      rd_ready  = 1'b0;
      aw_ready  = 1'b0;
      ar_ready  = 1'b0;
      w_ready   = 1'b0;
      r_data    = '0;
      r_resp    = 2'b00;
      r_last    = 1'b0;
      r_id      = '0;
      r_user    = '0;
      r_valid   = 1'b0;
      b_resp    = 2'b00;
      b_id      = '0;
      b_user    = '0;
      b_valid   = 1'b0;

      test_reset();
      test_write();
      test_read();
      test_read_err();
      test_backpressure();
      test_4k();
      test_reset_mid();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
